// File: rtl/alu_result_bcd_pkg.sv
// Shared constants for the ALU result BCD display block: FSM encodings and
// the active-low seven-segment code table.
package alu_result_bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Indexed by BCD code; entries 10..15 are not valid digits and show blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/alu_result_bcd_seven_seg_decoder.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment decoder
// with a forced-blank input used for leading-zero suppression.
module seven_seg_decoder
    import alu_result_bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : SEG_TABLE[digit];
    end

endmodule

// File: rtl/alu_result_bcd.sv
// Accepts an ALU result, converts it to BCD with a one-bit-per-clock
// double-dabble engine and holds registered seven-segment patterns.
// Optional build macro: SIGNED_DISPLAY_EN (two's complement input, sign on neg).
module alu_result_bcd
    import alu_result_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  neg,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    logic [1:0]          state;
    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    bin_q;
    logic [BW-1:0]       scratch_q;
    logic [BW-1:0]       adj;
    logic [BW-1:0]       scratch_n;
    logic [WIDTH-1:0]    bin_n;
    logic [DIGITS-1:0]   blank;
    logic [7*DIGITS-1:0] seg_n;
    logic                seen_nonzero;
    logic [BW-1:0]       bcd_q;
    logic [7*DIGITS-1:0] seg_q;

    // Held low while rst is asserted so no transfer can be accepted during reset.
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign bcd       = bcd_q;
    assign seg       = seg_q;

    // One double-dabble step: correct nibbles >= 5, then shift the pair left.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        {scratch_n, bin_n} = {adj, bin_q} << 1;
    end

    // Blank every digit above the most significant nonzero one; units always shown.
    always_comb begin
        seen_nonzero = 1'b0;
        blank        = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (scratch_n[4*i +: 4] != 4'd0)
                seen_nonzero = 1'b1;
            blank[i] = !seen_nonzero && (i != 0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seven_seg_decoder u_dec (
            .digit (scratch_n[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg_n[7*g +: 7])
        );
    end

`ifdef SIGNED_DISPLAY_EN
    logic neg_pend;
    logic neg_q;
    assign neg = neg_q;
`else
    assign neg = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            bin_q     <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            seg_q     <= {(7*DIGITS){1'b1}};
`ifdef SIGNED_DISPLAY_EN
            neg_pend  <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
`ifdef SIGNED_DISPLAY_EN
                        bin_q    <= in_data[WIDTH-1] ? -in_data : in_data;
                        neg_pend <= in_data[WIDTH-1];
`else
                        bin_q    <= in_data;
`endif
                        scratch_q <= '0;
                        count     <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_q <= scratch_n;
                    bin_q     <= bin_n;
                    count     <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= ST_DONE;
                        bcd_q <= scratch_n;
                        seg_q <= seg_n;
`ifdef SIGNED_DISPLAY_EN
                        neg_q <= neg_pend;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
